// File: rtl/block_fill_engine_pkg.sv
// Shared types and constants for the block fill engine.
package block_fill_engine_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        FILL = 2'd2
    } state_t;

    // Pattern selectors as driven on the mode input.
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_CONST = 2'd0;
    localparam mode_t MODE_INC   = 2'd1;
    localparam mode_t MODE_DEC   = 2'd2;
    localparam mode_t MODE_CHK   = 2'd3;

endpackage

// File: rtl/block_fill_engine_pattern.sv
// Pattern datapath: holds the captured sample, mode and word index, and
// produces the registered write data word for the fill sequence.
module fill_pattern_gen
    import block_fill_engine_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              capture,   // latch d/mode from the producer
    input  logic [DATA_W-1:0] d,
    input  mode_t             mode,
    input  logic              start,     // present pattern(0), index back to 0
    input  logic              advance,   // write completed: present pattern(idx+1)
    input  logic              clear,     // force wdata to zero (idle / end of block)
    output logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] sample_q;
    mode_t             mode_q;
    logic [DATA_W-1:0] idx_q;
    logic [DATA_W-1:0] idx_nxt;
    logic [DATA_W-1:0] pat_nxt;

    // Index only needs DATA_W bits: every pattern is taken modulo 2^DATA_W,
    // and the checker pattern only looks at the index LSB.
    assign idx_nxt = idx_q + DATA_W'(1);

    // Pattern value for the word after the one currently presented.
    always_comb begin
        pat_nxt = sample_q;
        case (mode_q)
            MODE_CONST: pat_nxt = sample_q;
            MODE_INC:   pat_nxt = sample_q + idx_nxt;
            MODE_DEC:   pat_nxt = sample_q - idx_nxt;
            MODE_CHK:   pat_nxt = idx_nxt[0] ? ~sample_q : sample_q;
            default:    pat_nxt = sample_q;
        endcase
    end

    // Capture the producer's sample and pattern mode at the handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_q <= '0;
            mode_q   <= MODE_CONST;
        end else if (capture) begin
            sample_q <= d;
            mode_q   <= mode;
        end
    end

    // Index and output word; clear wins so the word is zero outside a fill.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            wdata <= '0;
        end else if (clear) begin
            wdata <= '0;
        end else if (start) begin
            idx_q <= '0;
            wdata <= sample_q;
        end else if (advance) begin
            idx_q <= idx_nxt;
            wdata <= pat_nxt;
        end
    end

endmodule

// File: rtl/block_fill_engine.sv
// Block fill engine: takes one sample over the dav_/rfd handshake and writes
// a 2^BLK_LOG2-word block at sel*2^BLK_LOG2 with a pattern derived from it.
module block_fill_engine
    import block_fill_engine_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int BLK_LOG2 = 10,
    parameter  int SEL_W    = 4,
    localparam int ADDR_W   = SEL_W + BLK_LOG2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dav_,
    output logic              rfd,
    input  logic [DATA_W-1:0] d,
    input  logic [SEL_W-1:0]  sel,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              we,
    input  logic              mem_rdy,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = BLK_LOG2 + 1;
    localparam logic [CNT_W-1:0] BLK_WORDS = {1'b1, {BLK_LOG2{1'b0}}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               rfd_d, we_d, busy_d, done_d;
    logic               pg_capture, pg_start, pg_advance, pg_clear;

    fill_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .clock   (clock),
        .reset   (reset),
        .capture (pg_capture),
        .d       (d),
        .mode    (mode),
        .start   (pg_start),
        .advance (pg_advance),
        .clear   (pg_clear),
        .wdata   (wdata)
    );

    // State, address, counter and control outputs; all outputs are registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= BLK_WORDS;
            sel_q   <= '0;
            addr    <= '0;
            rfd     <= 1'b0;
            we      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            addr    <= addr_d;
            rfd     <= rfd_d;
            we      <= we_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state and next-output logic for the handshake and fill sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        addr_d     = addr;
        rfd_d      = rfd;
        we_d       = we;
        busy_d     = busy;
        done_d     = 1'b0;
        pg_capture = 1'b0;
        pg_start   = 1'b0;
        pg_advance = 1'b0;
        pg_clear   = 1'b0;

        case (state_q)
            IDLE: begin
                // rfd rises on the first edge out of reset; dav_ only counts
                // on an edge where rfd was already high.
                rfd_d    = 1'b1;
                we_d     = 1'b0;
                busy_d   = 1'b0;
                pg_clear = 1'b1;
                if (rfd && !dav_) begin
                    pg_capture = 1'b1;
                    sel_d      = sel;
                    rfd_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ACK;
                end
            end

            ACK: begin
                // Wait for the producer to release dav_, then present word 0.
                if (dav_) begin
                    addr_d   = {sel_q, {BLK_LOG2{1'b0}}};
                    cnt_d    = BLK_WORDS;
                    we_d     = 1'b1;
                    pg_start = 1'b1;
                    state_d  = FILL;
                end
            end

            FILL: begin
                we_d = 1'b1;
                if (mem_rdy) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        // Last word accepted: address stays on the final
                        // word so it never steps into the next block.
                        we_d     = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        rfd_d    = 1'b1;
                        pg_clear = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        addr_d     = addr + ADDR_W'(1);
                        pg_advance = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
